// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: RV32I/RV64I ops behind a valid/ready handshake.
// Optional iterative MUL/DIV/REM datapath is built when ALU_MULDIV_EN is defined.
module alu_exec_unit #(
   parameter int XLEN = 32,
   parameter int SHW  = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      ALUOp,
   input  logic            op5,
   input  logic [2:0]      funct3,
   input  logic [6:0]      funct7,
   input  logic [XLEN-1:0] SrcA,
   input  logic [XLEN-1:0] SrcB,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] Result,
   output logic            Zero,
   output logic            Illegal,
   output logic [3:0]      ALUControl
);

   localparam logic [3:0] C_ADD  = 4'd0,  C_SUB  = 4'd1,  C_SLL  = 4'd2,  C_SLT  = 4'd3;
   localparam logic [3:0] C_SLTU = 4'd4,  C_XOR  = 4'd5,  C_SRL  = 4'd6,  C_SRA  = 4'd7;
   localparam logic [3:0] C_OR   = 4'd8,  C_AND  = 4'd9,  C_MUL  = 4'd10, C_DIV  = 4'd11;
   localparam logic [3:0] C_DIVU = 4'd12, C_REM  = 4'd13, C_REMU = 4'd14, C_ILL  = 4'd15;

`ifdef ALU_MULDIV_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd2} state_t;
`endif

   state_t                  r_state;
   logic [XLEN-1:0]         r_result;
   logic                    r_zero;
   logic                    r_illegal;
   logic [3:0]              r_ctl;
   logic                    r_out_valid;

   logic [3:0]              w_ctl;
   logic [XLEN-1:0]         w_res;
   logic [SHW-1:0]          w_shamt;
   logic signed [XLEN-1:0]  w_sra;

   assign w_shamt = SrcB[SHW-1:0];
   assign w_sra   = $signed(SrcA) >>> w_shamt;

   always_comb begin
      w_ctl = C_ILL;
      case (ALUOp)
         2'b00: w_ctl = C_ADD;
         2'b01: w_ctl = C_SUB;
         2'b10: begin
            case (funct3)
               3'b000:  w_ctl = (op5 && funct7[5]) ? C_SUB : C_ADD;
               3'b001:  w_ctl = C_SLL;
               3'b010:  w_ctl = C_SLT;
               3'b011:  w_ctl = C_SLTU;
               3'b100:  w_ctl = C_XOR;
               3'b101:  w_ctl = funct7[5] ? C_SRA : C_SRL;
               3'b110:  w_ctl = C_OR;
               default: w_ctl = C_AND;
            endcase
         end
         default: begin
`ifdef ALU_MULDIV_EN
            if (funct7 == 7'b0000001) begin
               case (funct3)
                  3'b000:  w_ctl = C_MUL;
                  3'b100:  w_ctl = C_DIV;
                  3'b101:  w_ctl = C_DIVU;
                  3'b110:  w_ctl = C_REM;
                  3'b111:  w_ctl = C_REMU;
                  default: w_ctl = C_ILL;
               endcase
            end
`else
            w_ctl = C_ILL;
`endif
         end
      endcase
   end

   always_comb begin
      w_res = '0;
      case (w_ctl)
         C_ADD:   w_res = SrcA + SrcB;
         C_SUB:   w_res = SrcA - SrcB;
         C_SLL:   w_res = SrcA << w_shamt;
         C_SLT:   w_res = {{(XLEN-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
         C_SLTU:  w_res = {{(XLEN-1){1'b0}}, (SrcA < SrcB)};
         C_XOR:   w_res = SrcA ^ SrcB;
         C_SRL:   w_res = SrcA >> w_shamt;
         C_SRA:   w_res = w_sra;
         C_OR:    w_res = SrcA | SrcB;
         C_AND:   w_res = SrcA & SrcB;
         default: w_res = '0;
      endcase
   end

`ifdef ALU_MULDIV_EN
   localparam logic [SHW-1:0] CNT_LAST = SHW'(XLEN - 1);

   logic [SHW-1:0]  r_cnt;
   logic [XLEN-1:0] r_acc, r_mcand, r_mplier;
   logic [XLEN-1:0] r_rem, r_quo, r_dvs, r_srca;
   logic            r_neg_q, r_neg_r, r_dz;

   logic            w_is_md, w_sgn;
   logic [XLEN-1:0] w_abs_a, w_abs_b;
   logic [XLEN-1:0] w_acc_nxt, w_rem_nxt, w_quo_nxt, w_md_res;
   logic [XLEN:0]   w_sh;
   logic            w_ge;

   assign w_is_md = (w_ctl == C_MUL) || (w_ctl == C_DIV) || (w_ctl == C_DIVU) ||
                    (w_ctl == C_REM) || (w_ctl == C_REMU);
   assign w_sgn   = (w_ctl == C_DIV) || (w_ctl == C_REM);
   assign w_abs_a = (w_sgn && SrcA[XLEN-1]) ? -SrcA : SrcA;
   assign w_abs_b = (w_sgn && SrcB[XLEN-1]) ? -SrcB : SrcB;

   // One shift-add step and one restoring-division step per CALC cycle
   assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
   assign w_sh      = {r_rem, r_quo[XLEN-1]};
   assign w_ge      = (w_sh >= {1'b0, r_dvs});
   assign w_rem_nxt = w_ge ? (w_sh[XLEN-1:0] - r_dvs) : w_sh[XLEN-1:0];
   assign w_quo_nxt = {r_quo[XLEN-2:0], w_ge};

   // The final step's next values feed the result so CALC lasts exactly XLEN cycles
   always_comb begin
      w_md_res = w_acc_nxt;
      case (r_ctl)
         C_DIV, C_DIVU: w_md_res = r_dz ? '1 : (r_neg_q ? -w_quo_nxt : w_quo_nxt);
         C_REM, C_REMU: w_md_res = r_dz ? r_srca : (r_neg_r ? -w_rem_nxt : w_rem_nxt);
         default:       w_md_res = w_acc_nxt;
      endcase
   end

   always_ff @(posedge clk) begin
      if (r_state == S_IDLE && in_valid) begin
         r_acc    <= '0;
         r_mcand  <= SrcA;
         r_mplier <= SrcB;
         r_rem    <= '0;
         r_quo    <= w_abs_a;
         r_dvs    <= w_abs_b;
         r_srca   <= SrcA;
         r_neg_q  <= w_sgn && (SrcA[XLEN-1] ^ SrcB[XLEN-1]);
         r_neg_r  <= w_sgn && SrcA[XLEN-1];
         r_dz     <= (SrcB == '0);
      end else if (r_state == S_CALC) begin
         r_acc    <= w_acc_nxt;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_rem    <= w_rem_nxt;
         r_quo    <= w_quo_nxt;
      end
   end
`else
   logic w_unused_f7;
   assign w_unused_f7 = ^{funct7[6], funct7[4:0]};
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_result    <= '0;
         r_zero      <= 1'b0;
         r_illegal   <= 1'b0;
         r_ctl       <= 4'd0;
         r_out_valid <= 1'b0;
`ifdef ALU_MULDIV_EN
         r_cnt       <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_ctl       <= w_ctl;
                  r_result    <= w_res;
                  r_zero      <= (w_res == '0);
                  r_illegal   <= (w_ctl == C_ILL);
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
`ifdef ALU_MULDIV_EN
                  if (w_is_md) begin
                     r_out_valid <= 1'b0;
                     r_cnt       <= '0;
                     r_state     <= S_CALC;
                  end
`endif
               end
            end
`ifdef ALU_MULDIV_EN
            S_CALC: begin
               if (r_cnt == CNT_LAST) begin
                  r_result    <= w_md_res;
                  r_zero      <= (w_md_res == '0);
                  r_illegal   <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
`endif
            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready   = rst && (r_state == S_IDLE);
   assign out_valid  = r_out_valid;
   assign Result     = r_result;
   assign Zero       = r_zero;
   assign Illegal    = r_illegal;
   assign ALUControl = r_ctl;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit (XLEN=32); covers the ALU_MULDIV_EN build when the macro is defined.
module tb_alu_exec_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  ALUOp = 2'b00;
   logic        op5 = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [6:0]  funct7 = 7'b0;
   logic [31:0] SrcA = '0;
   logic [31:0] SrcB = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] Result;
   logic        Zero;
   logic        Illegal;
   logic [3:0]  ALUControl;

   int total = 0;
   int bad   = 0;

   alu_exec_unit #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .ALUOp(ALUOp), .op5(op5), .funct3(funct3), .funct7(funct7),
      .SrcA(SrcA), .SrcB(SrcB), .out_valid(out_valid), .out_ready(out_ready),
      .Result(Result), .Zero(Zero), .Illegal(Illegal), .ALUControl(ALUControl)
   );

   always #5 clk = ~clk;

   // Presents one request for one edge, scrambles operands afterwards, and
   // returns the number of edges until out_valid (1 = next cycle).
   task automatic issue(input logic [1:0] op, input logic o5, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
      ALUOp = op; op5 = o5; funct3 = f3; funct7 = f7; SrcA = a; SrcB = b;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      SrcA = 32'hDEADBEEF; SrcB = 32'h12345678;
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic drain();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      total++; if ({Result, Zero, Illegal, ALUControl} !== 38'd0)
         begin bad++; $display("FAIL rst_outputs: got R=%h Z=%b I=%b C=%h want all 0", Result, Zero, Illegal, ALUControl); end
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_add();
      int lat;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL add_ready: got %b want 1", in_ready); end
      issue(2'b00, 1'b0, 3'b000, 7'd0, 32'd5, 32'd7, lat);
      total++; if (lat !== 1) begin bad++; $display("FAIL add_latency: got %0d want 1", lat); end
      total++; if (Result !== 32'd12) begin bad++; $display("FAIL add_result: got %h want %h", Result, 32'd12); end
      total++; if (Zero !== 1'b0 || Illegal !== 1'b0) begin bad++; $display("FAIL add_flags: got Z=%b I=%b want 0 0", Zero, Illegal); end
      drain();
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
         begin bad++; $display("FAIL add_drain: got ov=%b ir=%b want 0 1", out_valid, in_ready); end
      issue(2'b00, 1'b0, 3'b000, 7'd0, 32'hFFFFFFFF, 32'd1, lat);
      total++; if (Result !== 32'd0 || Zero !== 1'b1) begin bad++; $display("FAIL add_wrap: got %h Z=%b want 0 Z=1", Result, Zero); end
      drain();
      issue(2'b01, 1'b0, 3'b000, 7'd0, 32'd0, 32'd1, lat);
      total++; if (Result !== 32'hFFFFFFFF) begin bad++; $display("FAIL sub_wrap: got %h want ffffffff", Result); end
      drain();
   endtask

   task automatic test_decode();
      int lat;
      issue(2'b10, 1'b1, 3'b000, 7'b0100000, 32'd3, 32'd3, lat);
      total++; if (Result !== 32'd0 || Zero !== 1'b1) begin bad++; $display("FAIL sub_zero: got %h Z=%b want 0 Z=1", Result, Zero); end
      drain();
      issue(2'b10, 1'b0, 3'b000, 7'b0100000, 32'd3, 32'd3, lat);
      total++; if (Result !== 32'd6) begin bad++; $display("FAIL addi_f7: got %h want 6", Result); end
      drain();
      issue(2'b10, 1'b1, 3'b101, 7'b0100000, 32'h80000000, 32'd4, lat);
      total++; if (Result !== 32'hF8000000) begin bad++; $display("FAIL sra: got %h want f8000000", Result); end
      drain();
      issue(2'b10, 1'b1, 3'b101, 7'b0000000, 32'h80000000, 32'd4, lat);
      total++; if (Result !== 32'h08000000) begin bad++; $display("FAIL srl: got %h want 08000000", Result); end
      drain();
      issue(2'b10, 1'b1, 3'b011, 7'd0, 32'd1, 32'hFFFFFFFF, lat);
      total++; if (Result !== 32'd1) begin bad++; $display("FAIL sltu: got %h want 1", Result); end
      drain();
      issue(2'b10, 1'b1, 3'b010, 7'd0, 32'd1, 32'hFFFFFFFF, lat);
      total++; if (Result !== 32'd0) begin bad++; $display("FAIL slt_signed: got %h want 0", Result); end
      drain();
      issue(2'b10, 1'b1, 3'b001, 7'd0, 32'd1, 32'd35, lat);
      total++; if (Result !== 32'd8) begin bad++; $display("FAIL sll_shamt: got %h want 8", Result); end
      drain();
      issue(2'b10, 1'b1, 3'b111, 7'd0, 32'hF0F0F0F0, 32'hFF00FF00, lat);
      total++; if (Result !== 32'hF000F000) begin bad++; $display("FAIL and: got %h want f000f000", Result); end
      drain();
      issue(2'b10, 1'b1, 3'b110, 7'd0, 32'hF0F0F0F0, 32'h0000FF00, lat);
      total++; if (Result !== 32'hF0F0FFF0) begin bad++; $display("FAIL or: got %h want f0f0fff0", Result); end
      drain();
   endtask

   task automatic test_back_to_back();
      int lat;
      bit ok = 1'b1;
      issue(2'b10, 1'b1, 3'b100, 7'd0, 32'hF0F0F0F0, 32'hFF00FF00, lat);
      total++; if (Result !== 32'h0FF00FF0) begin bad++; $display("FAIL xor: got %h want 0ff00ff0", Result); end
      ALUOp = 2'b00; SrcA = 32'd1; SrcB = 32'd1; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (Result !== 32'h0FF00FF0 || out_valid !== 1'b1 || in_ready !== 1'b0) ok = 1'b0;
      end
      total++; if (!ok) begin bad++; $display("FAIL hold_stable: got R=%h ov=%b ir=%b want 0ff00ff0 1 0", Result, out_valid, in_ready); end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
         begin bad++; $display("FAIL b2b_idle: got ov=%b ir=%b want 0 1", out_valid, in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b1 || Result !== 32'd2)
         begin bad++; $display("FAIL b2b_second: got ov=%b R=%h want 1 2", out_valid, Result); end
      drain();
   endtask

   task automatic test_illegal();
      int lat;
      issue(2'b11, 1'b1, 3'b001, 7'b0000001, 32'd9, 32'd4, lat);
      total++; if (lat !== 1) begin bad++; $display("FAIL ill_latency: got %0d want 1", lat); end
      total++; if (Illegal !== 1'b1 || Result !== 32'd0 || Zero !== 1'b1)
         begin bad++; $display("FAIL ill_outputs: got I=%b R=%h Z=%b want 1 0 1", Illegal, Result, Zero); end
      drain();
      issue(2'b11, 1'b1, 3'b000, 7'b0100000, 32'd9, 32'd4, lat);
      total++; if (Illegal !== 1'b1 || lat !== 1) begin bad++; $display("FAIL ill_funct7: got I=%b lat=%0d want 1 1", Illegal, lat); end
      drain();
   endtask

`ifdef ALU_MULDIV_EN
   task automatic test_muldiv();
      int lat;
      bit ok = 1'b1;
      ALUOp = 2'b11; op5 = 1'b1; funct3 = 3'b000; funct7 = 7'b0000001;
      SrcA = 32'hFFFFFFFF; SrcB = 32'd3; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; SrcA = 32'd0; SrcB = 32'd0;
      lat = 1;
      while (!out_valid && lat < 200) begin
         if (in_ready !== 1'b0) ok = 1'b0;
         @(posedge clk); #1;
         lat++;
      end
      total++; if (!ok) begin bad++; $display("FAIL mul_busy: got in_ready high during CALC want 0"); end
      total++; if (lat !== 33) begin bad++; $display("FAIL mul_latency: got %0d want 33", lat); end
      total++; if (Result !== 32'hFFFFFFFD) begin bad++; $display("FAIL mul_result: got %h want fffffffd", Result); end
      ok = 1'b1; in_valid = 1'b1; ALUOp = 2'b00;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (Result !== 32'hFFFFFFFD || in_ready !== 1'b0 || out_valid !== 1'b1) ok = 1'b0;
      end
      in_valid = 1'b0;
      total++; if (!ok) begin bad++; $display("FAIL mul_hold: got R=%h ir=%b want fffffffd 0", Result, in_ready); end
      drain();
      issue(2'b11, 1'b1, 3'b100, 7'b0000001, 32'd7, 32'd0, lat);
      total++; if (Result !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_by_zero: got %h want ffffffff", Result); end
      drain();
      issue(2'b11, 1'b1, 3'b110, 7'b0000001, 32'hFFFFFFF9, 32'd2, lat);
      total++; if (Result !== 32'hFFFFFFFF) begin bad++; $display("FAIL rem_neg: got %h want ffffffff", Result); end
      drain();
      issue(2'b11, 1'b1, 3'b100, 7'b0000001, 32'h80000000, 32'hFFFFFFFF, lat);
      total++; if (Result !== 32'h80000000) begin bad++; $display("FAIL div_ovf: got %h want 80000000", Result); end
      drain();
      issue(2'b11, 1'b1, 3'b111, 7'b0000001, 32'd7, 32'd0, lat);
      total++; if (Result !== 32'd7) begin bad++; $display("FAIL remu_zero: got %h want 7", Result); end
      drain();
      issue(2'b11, 1'b1, 3'b100, 7'b0000001, 32'hFFFFFF9C, 32'd7, lat);
      total++; if (Result !== 32'hFFFFFFF2) begin bad++; $display("FAIL div_signed: got %h want fffffff2", Result); end
      drain();
      issue(2'b11, 1'b1, 3'b101, 7'b0000001, 32'hFFFFFFFE, 32'd2, lat);
      total++; if (Result !== 32'h7FFFFFFF) begin bad++; $display("FAIL divu: got %h want 7fffffff", Result); end
      drain();
   endtask
`else
   task automatic test_muldiv();
      int lat;
      issue(2'b11, 1'b1, 3'b000, 7'b0000001, 32'hFFFFFFFF, 32'd3, lat);
      total++; if (lat !== 1) begin bad++; $display("FAIL mul_off_latency: got %0d want 1", lat); end
      total++; if (Illegal !== 1'b1 || Result !== 32'd0 || Zero !== 1'b1)
         begin bad++; $display("FAIL mul_off_outputs: got I=%b R=%h Z=%b want 1 0 1", Illegal, Result, Zero); end
      drain();
      issue(2'b11, 1'b1, 3'b100, 7'b0000001, 32'd7, 32'd0, lat);
      total++; if (Illegal !== 1'b1 || lat !== 1) begin bad++; $display("FAIL div_off: got I=%b lat=%0d want 1 1", Illegal, lat); end
      drain();
   endtask
`endif

   task automatic test_reset_mid();
      int lat;
      ALUOp = 2'b11; op5 = 1'b1; funct3 = 3'b100; funct7 = 7'b0000001;
      SrcA = 32'd100; SrcB = 32'd7; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      total++; if ({out_valid, in_ready, Zero, Illegal, ALUControl, Result} !== 40'd0)
         begin bad++; $display("FAIL rst_mid: got ov=%b ir=%b Z=%b I=%b C=%h R=%h want all 0", out_valid, in_ready, Zero, Illegal, ALUControl, Result); end
      @(negedge clk); rst = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
         begin bad++; $display("FAIL rst_no_stale: got ov=%b ir=%b want 0 1", out_valid, in_ready); end
      issue(2'b00, 1'b0, 3'b000, 7'd0, 32'd10, 32'd20, lat);
      total++; if (Result !== 32'd30 || lat !== 1) begin bad++; $display("FAIL rst_then_add: got %h lat=%0d want 1e lat=1", Result, lat); end
      drain();
   endtask

   initial begin
      test_reset();
      test_add();
      test_decode();
      test_back_to_back();
      test_illegal();
      test_muldiv();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised successor to the single-cycle ALU control decoder.
- Decodes ALUOp/op5/funct3/funct7 and executes the operation in one registered block.
- Covers the full RV32I/RV64I ALU op set plus optional iterative MUL/DIV/REM.
- Sits in the execute stage behind a valid/ready handshake, so multi-cycle ops can stall the core.

Parameters:
XLEN, 32, operand/result width in bits; legal values 32 and 64.
SHW, $clog2(XLEN), shift-amount width (derived; do not override).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous active-low reset.
in_valid  input  1  operation request.
in_ready  output  1  unit can accept a request this cycle.
ALUOp  input  2  00 add, 01 sub, 10 decode funct3/funct7, 11 M-extension.
op5  input  1  opcode bit 5 (1 = R-type).
funct3  input  3  instruction funct3.
funct7  input  7  instruction funct7.
SrcA  input  XLEN  operand A.
SrcB  input  XLEN  operand B.
out_valid  output  1  Result/Zero/Illegal valid.
out_ready  input  1  consumer accepts the result.
Result  output  XLEN  operation result.
Zero  output  1  Result == 0.
Illegal  output  1  op not supported.
ALUControl  output  4  decoded op code, registered at accept, for debug.

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE.
  - Result, Zero, Illegal, ALUControl, out_valid are all 0; in_ready=0 while in reset.
  - Any in-flight op is discarded.
- States:
  - IDLE: in_ready=1. When in_valid=1, latch operands and decoded op. Go to DONE for single-cycle ops, or CALC for MUL/DIV/REM.
  - CALC: in_ready=0. Run XLEN iterations, then go to DONE.
  - DONE: out_valid=1 and outputs held stable. When out_ready=1, go to IDLE. No accept occurs in DONE.
- Latency and throughput:
  - Single-cycle ops: out_valid one cycle after accept.
  - MUL/DIV/REM: out_valid XLEN+1 cycles after accept.
  - Peak throughput is one op per 2 cycles.
- Operands are captured at accept; input changes afterwards have no effect.
- Decode:
  - ALUOp=00: ADD.
  - ALUOp=01: SUB.
  - ALUOp=10, by funct3:
    - 000: SUB if op5 & funct7[5], else ADD.
    - 001: SLL.
    - 010: SLT (signed).
    - 011: SLTU.
    - 100: XOR.
    - 101: SRA if funct7[5], else SRL.
    - 110: OR.
    - 111: AND.
  - ALUOp=11, when the M-extension is enabled and funct7=0000001, by funct3:
    - 000: MUL (low XLEN bits).
    - 100: DIV.
    - 101: DIVU.
    - 110: REM.
    - 111: REMU.
  - Other ALUOp=11 encodings (funct3 001-011, or any other funct7) are illegal.
- Arithmetic:
  - Add/sub wrap modulo 2^XLEN.
  - Shift amount = SrcB[SHW-1:0].
  - SLT/SLTU return 0 or 1, zero-extended.
- MUL: shift-add, one bit per cycle; result is the low XLEN bits, so the sign is irrelevant.
- DIV/REM:
  - Restoring division on magnitudes, one bit per cycle, with signs corrected at the end.
  - Quotient takes the sign of A xor B; remainder takes the sign of A.
  - Divide by zero: quotient = all ones, remainder = SrcA.
  - Signed overflow (MIN / -1): quotient = MIN, remainder = 0.
- Illegal ops: Result=0, Zero=1, Illegal=1, one-cycle latency.
- Reset mid-CALC aborts the op with no stale output after reset release.

Optional Feature:
- Macro ALU_MULDIV_EN:
  - Defined: CALC state and the MUL/DIV/REM datapath are built, decoded as above.
  - Undefined: no CALC state or iterative datapath. Every ALUOp=11 op is Illegal with one-cycle latency; ALUOp 00/01/10 behaviour is unchanged.

Test Plan:
- ADD 5+7, ALUOp=00: accepted with in_ready=1 -> next cycle out_valid=1, Result=12, Zero=0.
- SUB 3-3, ALUOp=10, funct3=000, op5=1, funct7=0100000 -> Result=0, Zero=1.
- SRA 0x80000000 by 4, then SLTU 1<0xFFFFFFFF:
  - SRA -> Result=0xF8000000.
  - SLTU -> Result=1.
- MUL 0xFFFFFFFF*3 (ALU_MULDIV_EN, XLEN=32):
  - in_ready=0 for 32 cycles.
  - out_valid at cycle 33 with Result=0xFFFFFFFD.
  - Holding out_ready=0 for 5 cycles keeps Result stable and blocks new requests.
- Division corner cases:
  - DIV 7/0 -> 0xFFFFFFFF.
  - REM -7%2 -> 0xFFFFFFFF.
  - DIV 0x80000000/-1 -> 0x80000000.
  - REMU 7%0 -> 7.
- Illegal and reset:
  - ALUOp=11, funct3=001 -> Illegal=1, Result=0.
  - rst=0 asserted mid-DIV -> all outputs 0 immediately.
  - After release, in_ready=1 and the next ADD is correct.
